m_toggle_decoder: RTL

//  Receive end of a toggle-signalled event line: each event on TGL_IN is a level change, as

---
 rtl/m_cnt_pkg.sv | 20 ++
 rtl/m_sync_ff.sv | 32 +++
 rtl/m_toggle_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/m_cnt_pkg.sv
// Shared definitions for the counter / event-sink family: FSM state encodings
// and a constant log2 helper usable in port and parameter declarations.
`timescale 1ns/1ps
package m_cnt_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ACTIVE  = 2'b01;
    localparam logic [1:0] ST_STALLED = 2'b10;

    // Number of bits needed to hold values 0..value-1 (same result as $clog2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/m_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level into the clk domain.
// Reset clears every stage so the output starts low after reset release.
`timescale 1ns/1ps
module m_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the sampled level one stage deeper each clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchroniser stages with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/m_toggle_decoder.sv
// Toggle-encoded event receiver: synchronises TGL_IN, turns each level change
// into a one-cycle EVT, counts events with sticky overflow and watches the line
// for inactivity (IDLE -> ACTIVE -> STALLED). Every output is a flop.
`timescale 1ns/1ps
module m_toggle_decoder
    import m_cnt_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000,
    parameter bit SATURATE    = 1'b0
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             TGL_IN,
    input  logic                             CLR,
    output logic                             EVT,
    output logic [WIDTH-1:0]                 COUNT,
    output logic                             OVF,
    output logic [1:0]                       STATE,
    output logic [clog2(TIMEOUT+1)-1:0]      IDLE_CNT
);

    localparam int                IDLE_W   = clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;

    logic              sync_last;
    logic              tgl_det;
    logic              prev_q,  prev_d;
    logic              evt_q,   evt_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              ovf_q,   ovf_d;
    logic [IDLE_W-1:0] idle_q,  idle_d;
    logic [1:0]        state_q, state_d;

    m_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (TGL_IN),
        .q     (sync_last)
    );

    // A toggle is any difference between the synchronised level and the level seen last cycle.
    always_comb begin
        tgl_det = sync_last ^ prev_q;
        prev_d  = sync_last;
        evt_d   = tgl_det;
    end

    // Event counter: advances the cycle after EVT; CLR wins and drops a coincident event.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (CLR) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (evt_q) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
                if (!SATURATE) begin
                    count_d = '0;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Idle timer: zero on a detected toggle (aligned with EVT rising), else count up to TIMEOUT.
    always_comb begin
        idle_d = idle_q;
        if (CLR || tgl_det) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Activity FSM: stalls when the timer reaches TIMEOUT while ACTIVE; IDLE never times out.
    always_comb begin
        state_d = state_q;
        if (CLR) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tgl_det) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!tgl_det && (idle_d == IDLE_MAX)) state_d = ST_STALLED;
                end
                ST_STALLED: begin
                    if (tgl_det) state_d = ST_ACTIVE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // All state registers share the asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q  <= 1'b0;
            evt_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            idle_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            prev_q  <= prev_d;
            evt_q   <= evt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            idle_q  <= idle_d;
            state_q <= state_d;
        end
    end

    assign EVT      = evt_q;
    assign COUNT    = count_q;
    assign OVF      = ovf_q;
    assign STATE    = state_q;
    assign IDLE_CNT = idle_q;

endmodule
